// File: rtl/reaction_counter.sv
// Millisecond BCD reaction-time counter driven by the game state machine.
// Counts while the game is in run and captures the count on the run->done edge.
module reaction_counter #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [1:0]  state,
    output logic [15:0] time_bcd,
    output logic [15:0] result_bcd,
    output logic        result_valid,
    output logic        overflow,
    output logic        running
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

    logic [1:0]    prev_state_reg;
    logic [PW-1:0] prescaler_reg;
    logic [15:0]   count_reg;
    logic [15:0]   count_next;
    logic [15:0]   result_reg;
    logic          result_valid_reg;
    logic          overflow_reg;
    logic          running_reg;

    logic          in_run;
    logic          run_entry;
    logic          run_exit;
    logic          tick;
    logic          all_nines;
    logic          inc_en;
    logic [4:0]    carry;

    assign in_run    = (state == ST_RUN);
    assign run_entry = in_run && (prev_state_reg != ST_RUN);
    assign run_exit  = !in_run && (prev_state_reg == ST_RUN);
    assign tick      = in_run && !run_entry && (prescaler_reg == PRESC_LAST);
    assign all_nines = (count_reg == 16'h9999);
    assign inc_en    = tick && !all_nines;
    assign carry[0]  = inc_en;

    // Ripple carry across the four digits; each digit wraps 9->0 and feeds the next.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit         = count_reg[gi*4 +: 4];
            assign carry[gi+1]   = carry[gi] && (digit == 4'd9);
            assign count_next[gi*4 +: 4] =
                run_entry ? 4'd0 :
                carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) :
                digit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            prev_state_reg   <= 2'b00;
            prescaler_reg    <= '0;
            count_reg        <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
            running_reg      <= 1'b0;
        end else begin
            prev_state_reg   <= state;
            running_reg      <= in_run;
            result_valid_reg <= 1'b0;
            count_reg        <= count_next;
            if (in_run) begin
                if (run_entry) begin
                    prescaler_reg <= '0;
                    overflow_reg  <= 1'b0;
                end else begin
                    prescaler_reg <= tick ? '0 : prescaler_reg + PW'(1);
                    if (tick && all_nines)
                        overflow_reg <= 1'b1;
                end
            end else begin
                // Partial millisecond is dropped whenever the game is not in run.
                prescaler_reg <= '0;
                if (run_exit && state == ST_DONE) begin
                    result_reg       <= count_reg;
                    result_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign time_bcd     = count_reg;
    assign result_bcd   = result_reg;
    assign result_valid = result_valid_reg;
    assign overflow     = overflow_reg;
    assign running      = running_reg;

endmodule

// File: tb/tb_reaction_counter.sv
// Randomized bench for reaction_counter against an elapsed-cycle arithmetic model.
// The model derives the count as elapsed/TICKS_PER_MS, saturated at 9999.
module tb_reaction_counter;

    localparam int T = 4;

    logic        clk;
    logic        clear;
    logic [1:0]  state;
    logic [15:0] time_bcd;
    logic [15:0] result_bcd;
    logic        result_valid;
    logic        overflow;
    logic        running;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int seg_no = 0;

    // Reference model state
    int         m_elapsed = 0;
    int         m_count = 0;
    int         m_result = 0;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_running = 1'b0;
    logic [1:0] m_prev = 2'b00;

    reaction_counter #(.TICKS_PER_MS(T)) dut (
        .clk          (clk),
        .clear        (clear),
        .state        (state),
        .time_bcd     (time_bcd),
        .result_bcd   (result_bcd),
        .result_valid (result_valid),
        .overflow     (overflow),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic is_bcd(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic clr, input logic [1:0] st);
        int ms;
        if (clr) begin
            m_elapsed = 0; m_count = 0; m_result = 0;
            m_valid = 1'b0; m_ovf = 1'b0; m_running = 1'b0; m_prev = 2'b00;
        end else begin
            m_valid = 1'b0;
            if (st == 2'b10) begin
                if (m_prev != 2'b10) begin
                    m_elapsed = 0; m_count = 0; m_ovf = 1'b0;
                end else begin
                    m_elapsed++;
                    ms = m_elapsed / T;
                    m_count = (ms > 9999) ? 9999 : ms;
                    if (ms >= 10000) m_ovf = 1'b1;
                end
            end else if (m_prev == 2'b10 && st == 2'b11) begin
                m_result = m_count;
                m_valid = 1'b1;
            end
            m_running = (st == 2'b10);
            m_prev = st;
        end
    endtask

    task automatic step(input logic clr, input logic [1:0] st);
        @(negedge clk);
        clear = clr;
        state = st;
        @(posedge clk);
        model_update(clr, st);
        #1;
        if (result_valid === 1'b1) pulse_cnt++;
        check("time_bcd", {16'h0, time_bcd}, {16'h0, to_bcd(m_count)});
        check("result_bcd", {16'h0, result_bcd}, {16'h0, to_bcd(m_result)});
        check("result_valid", {31'h0, result_valid}, {31'h0, m_valid});
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        check("running", {31'h0, running}, {31'h0, m_running});
        check("bcd_digits", {31'h0, is_bcd(time_bcd)}, 32'd1);
    endtask

    task automatic seg(input logic [1:0] st, input int n);
        for (int i = 0; i < n; i++) step(1'b0, st);
        seg_no++;
        $display("seg %0d state=%b cycles=%0d time=%h result=%h ovf=%b",
                 seg_no, st, n, time_bcd, result_bcd, overflow);
    endtask

    initial begin
        clear = 1'b1;
        state = 2'b00;

        // Reset: clear for two cycles in a non-idle state, then release in idle
        step(1'b1, 2'b10);
        step(1'b1, 2'b11);
        check("reset_time", {16'h0, time_bcd}, 32'h0);
        check("reset_result", {16'h0, result_bcd}, 32'h0);
        check("reset_flags", {29'h0, result_valid, overflow, running}, 32'h0);
        seg(2'b00, 3);
        check("post_reset_time", {16'h0, time_bcd}, 32'h0);

        // Basic run: 41 cycles in run gives exactly 10 ms
        pulse_cnt = 0;
        seg(2'b01, 3);
        seg(2'b10, 41);
        step(1'b0, 2'b11);
        check("basic_result", {16'h0, result_bcd}, 32'h0010);
        check("basic_valid", {31'h0, result_valid}, 32'd1);
        seg(2'b11, 3);
        check("basic_time", {16'h0, time_bcd}, 32'h0010);
        check("basic_pulses", pulse_cnt, 32'd1);
        check("basic_ovf", {31'h0, overflow}, 32'd0);

        // BCD carry chain
        seg(2'b00, 2);
        seg(2'b10, 1 + 99 * T);
        check("carry_0099", {16'h0, time_bcd}, 32'h0099);
        seg(2'b10, T);
        check("carry_0100", {16'h0, time_bcd}, 32'h0100);
        seg(2'b10, 899 * T);
        check("carry_0999", {16'h0, time_bcd}, 32'h0999);
        seg(2'b10, T);
        check("carry_1000", {16'h0, time_bcd}, 32'h1000);
        seg(2'b11, 2);

        // Saturation at 9999 with overflow
        seg(2'b01, 2);
        pulse_cnt = 0;
        seg(2'b10, 40010);
        check("sat_time", {16'h0, time_bcd}, 32'h9999);
        check("sat_ovf", {31'h0, overflow}, 32'd1);
        seg(2'b11, 3);
        check("sat_result", {16'h0, result_bcd}, 32'h9999);
        check("sat_pulses", pulse_cnt, 32'd1);

        // Clear mid-run, then restart from zero with state still in run
        seg(2'b00, 2);
        seg(2'b10, 1 + 5 * T);
        check("mid_0005", {16'h0, time_bcd}, 32'h0005);
        pulse_cnt = 0;
        step(1'b1, 2'b10);
        check("clr_time", {16'h0, time_bcd}, 32'h0);
        check("clr_result", {16'h0, result_bcd}, 32'h0);
        check("clr_flags", {29'h0, result_valid, overflow, running}, 32'h0);
        seg(2'b10, 1 + 3 * T);
        check("restart_0003", {16'h0, time_bcd}, 32'h0003);
        seg(2'b00, 2);
        check("clr_no_pulse", pulse_cnt, 32'd0);

        // Re-arm: values hold through done/idle/delay; new run clears live count only
        seg(2'b01, 2);
        seg(2'b10, 41);
        seg(2'b11, 2);
        seg(2'b00, 2);
        seg(2'b01, 2);
        check("rearm_time", {16'h0, time_bcd}, 32'h0010);
        check("rearm_result", {16'h0, result_bcd}, 32'h0010);
        step(1'b0, 2'b10);
        check("rearm_entry_time", {16'h0, time_bcd}, 32'h0);
        check("rearm_entry_result", {16'h0, result_bcd}, 32'h0010);
        seg(2'b10, 3 * T);
        check("rearm_hold_result", {16'h0, result_bcd}, 32'h0010);
        seg(2'b11, 2);
        check("rearm_new_result", {16'h0, result_bcd}, 32'h0003);

        // Randomized state sequences with occasional clears
        for (int k = 0; k < 150; k++) begin
            logic [1:0] st;
            st = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) begin
                step(1'b1, st);
                seg_no++;
                $display("seg %0d clear state=%b", seg_no, st);
            end else if (st == 2'b10) begin
                seg(st, $urandom_range(1, 120));
            end else begin
                seg(st, $urandom_range(1, 12));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
